// File: rtl/seven_seg_scanner.sv
// seven_seg_scanner: time-multiplexed active-low 7-segment scanner with anti-ghost blanking.
// Optional LEADING_ZERO_BLANK_EN suppresses a zero on the most significant digit.
module seven_seg_scanner #(
   parameter int NUM_DIGITS   = 4,
   parameter int REFRESH_DIV  = 100000,
   parameter int BLANK_CYCLES = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  en,
   input  logic [3:0]            hex_val,
   output logic [2:0]            digit_sel,
   output logic [NUM_DIGITS-1:0] an_n,
   output logic [6:0]            seg_n,
   output logic                  frame_tick
);
   localparam int TW = $clog2(REFRESH_DIV);
   logic [TW-1:0]         tick_cnt, tick_nx;
   logic [2:0]            sel_nx;
   logic                  slot_end, wrap, show;
   logic [NUM_DIGITS-1:0] an_nx;

   function automatic logic [6:0] dec(input logic [3:0] v);
      case (v)
         4'h0: dec = 7'b1000000;
         4'h1: dec = 7'b1111001;
         4'h2: dec = 7'b0100100;
         4'h3: dec = 7'b0110000;
         4'h4: dec = 7'b0011001;
         4'h5: dec = 7'b0010010;
         4'h6: dec = 7'b0000010;
         4'h7: dec = 7'b1111000;
         4'h8: dec = 7'b0000000;
         4'h9: dec = 7'b0010000;
         4'hA: dec = 7'b0001000;
         4'hB: dec = 7'b0000011;
         4'hC: dec = 7'b1000110;
         4'hD: dec = 7'b0100001;
         4'hE: dec = 7'b0000110;
         default: dec = 7'b0001110;
      endcase
   endfunction

   // Anodes are computed from the next slot position so they line up with the registered scan state.
   always_comb begin
      slot_end = tick_cnt == TW'(REFRESH_DIV - 1);
      wrap     = slot_end && digit_sel == 3'(NUM_DIGITS - 1);
      tick_nx  = slot_end ? '0 : tick_cnt + TW'(1);
      sel_nx   = wrap ? 3'd0 : slot_end ? digit_sel + 3'd1 : digit_sel;
`ifdef LEADING_ZERO_BLANK_EN
      show     = en && tick_nx >= TW'(BLANK_CYCLES) &&
                 !(sel_nx == 3'(NUM_DIGITS - 1) && hex_val == 4'h0);
`else
      show     = en && tick_nx >= TW'(BLANK_CYCLES);
`endif
      an_nx    = show ? ~(NUM_DIGITS'(1) << sel_nx) : '1;
   end

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         tick_cnt   <= '0;
         digit_sel  <= '0;
         an_n       <= '1;
         seg_n      <= 7'h7F;
         frame_tick <= 1'b0;
      end else begin
         tick_cnt   <= tick_nx;
         digit_sel  <= sel_nx;
         an_n       <= an_nx;
         seg_n      <= dec(hex_val);
         frame_tick <= wrap;
      end
endmodule

// File: tb/tb_seven_seg_scanner.sv
// tb_seven_seg_scanner: directed table-driven bench for the scanner, plus a short-slot instance.
module tb_seven_seg_scanner;
   logic clk = 0, rst_n = 1, en = 1;
   logic [15:0] val = 16'hF80C;
   logic [3:0] hex_val, hex3, an_n, an3;
   logic [2:0] digit_sel, sel3;
   logic [6:0] seg_n, seg3;
   logic frame_tick, ft3;
   int cmp = 0, bad = 0;

   always #5 clk = ~clk;
   assign hex_val = val[{digit_sel[1:0], 2'b00} +: 4];
   assign hex3    = val[{sel3[1:0], 2'b00} +: 4];

   seven_seg_scanner #(.NUM_DIGITS(4), .REFRESH_DIV(4), .BLANK_CYCLES(1)) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .hex_val(hex_val),
      .digit_sel(digit_sel), .an_n(an_n), .seg_n(seg_n), .frame_tick(frame_tick));

   seven_seg_scanner #(.NUM_DIGITS(4), .REFRESH_DIV(3), .BLANK_CYCLES(2)) dut3 (
      .clk(clk), .rst_n(rst_n), .en(en), .hex_val(hex3),
      .digit_sel(sel3), .an_n(an3), .seg_n(seg3), .frame_tick(ft3));

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      cmp++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   task automatic step(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // At most one anode low in either instance, every cycle.
   always @(negedge clk) begin
      cmp++;
      if ($countones(~an_n) > 1 || $countones(~an3) > 1) begin
         bad++;
         $display("FAIL one_hot_anode: got an_n=%b an3=%b want <=1 low", an_n, an3);
      end
   end

   typedef struct {
      logic [2:0] dig;
      logic [3:0] an;
      logic       ft;
      logic [6:0] seg;
      logic       sc;
   } vec_t;

   vec_t sv[17];
   logic [6:0] dt[16];
   int c3, ftc;

   initial begin
      sv[0]  = '{3'd0, 4'b1111, 1'b0, 7'h7F, 1'b1};
      sv[1]  = '{3'd0, 4'b1110, 1'b0, 7'b1000110, 1'b1};
      sv[2]  = '{3'd0, 4'b1110, 1'b0, 7'b1000110, 1'b1};
      sv[3]  = '{3'd0, 4'b1110, 1'b0, 7'b1000110, 1'b1};
      sv[4]  = '{3'd1, 4'b1111, 1'b0, 7'h00, 1'b0};
      sv[5]  = '{3'd1, 4'b1101, 1'b0, 7'b1000000, 1'b1};
      sv[6]  = '{3'd1, 4'b1101, 1'b0, 7'b1000000, 1'b1};
      sv[7]  = '{3'd1, 4'b1101, 1'b0, 7'b1000000, 1'b1};
      sv[8]  = '{3'd2, 4'b1111, 1'b0, 7'h00, 1'b0};
      sv[9]  = '{3'd2, 4'b1011, 1'b0, 7'b0000000, 1'b1};
      sv[10] = '{3'd2, 4'b1011, 1'b0, 7'b0000000, 1'b1};
      sv[11] = '{3'd2, 4'b1011, 1'b0, 7'b0000000, 1'b1};
      sv[12] = '{3'd3, 4'b1111, 1'b0, 7'h00, 1'b0};
      sv[13] = '{3'd3, 4'b0111, 1'b0, 7'b0001110, 1'b1};
      sv[14] = '{3'd3, 4'b0111, 1'b0, 7'b0001110, 1'b1};
      sv[15] = '{3'd3, 4'b0111, 1'b0, 7'b0001110, 1'b1};
      sv[16] = '{3'd0, 4'b1111, 1'b1, 7'h00, 1'b0};
      dt = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
             7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
             7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
             7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

      #1 rst_n = 0;
      #11 rst_n = 1;
      c3 = 0;
      for (int i = 0; i < 17; i++) begin
         if (i > 0) step();
         chk($sformatf("start_dig[%0d]", i), digit_sel, sv[i].dig);
         chk($sformatf("start_an[%0d]", i), an_n, sv[i].an);
         chk($sformatf("start_ft[%0d]", i), frame_tick, sv[i].ft);
         if (sv[i].sc) chk($sformatf("start_seg[%0d]", i), seg_n, sv[i].seg);
         if (i > 0 && an3 !== 4'hF) c3++;
         if (i == 12) chk("short_ft_at_12", ft3, 1'b1);
      end
      chk("short_show_cycles", c3, 5);

      for (int k = 0; k < 16; k++) begin
         logic [3:0] nb;
         nb = k[3:0];
         val = {4{nb}};
         step(2);
         chk($sformatf("decode[%0h]", nb), seg_n, dt[k]);
      end

      en = 0;
      ftc = 0;
      for (int i = 1; i <= 16; i++) begin
         step();
         chk($sformatf("en0_an[%0d]", i), an_n, 4'hF);
         chk($sformatf("en0_dig[%0d]", i), digit_sel, ((48 + i) / 4) % 4);
         if (frame_tick) ftc++;
      end
      chk("en0_frame_ticks", ftc, 1);
      en = 1;
      step();
      chk("en1_resume_an", an_n, 4'b1110);
      chk("en1_resume_dig", digit_sel, 3'd0);

      val = 16'h0123;
      step(12);
`ifdef LEADING_ZERO_BLANK_EN
      chk("lz_0123_d3_an", an_n, 4'b1111);
`else
      chk("lz_0123_d3_an", an_n, 4'b0111);
`endif
      val = 16'h1123;
      step();
      chk("lz_1123_d3_an", an_n, 4'b0111);

      step(11);
      chk("pre_rst_d2_an", an_n, 4'b1011);
      #2 rst_n = 0;
      #1;
      chk("async_rst_an", an_n, 4'hF);
      chk("async_rst_seg", seg_n, 7'h7F);
      chk("async_rst_dig", digit_sel, 3'd0);
      chk("async_rst_ft", frame_tick, 1'b0);
      @(posedge clk);
      #2 rst_n = 1;
      chk("held_rst_an", an_n, 4'hF);
      step();
      chk("post_rst_dig", digit_sel, 3'd0);
      chk("post_rst_an", an_n, 4'b1110);
      step(3);
      chk("post_rst_slot1_dig", digit_sel, 3'd1);
      chk("post_rst_slot1_an", an_n, 4'b1111);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
      $finish;
   end
endmodule
